// File: rtl/rgb_value_sampler_if.sv
// Bundle between the VGA timing stage and the RGB value sampler: scan counters
// and pixel in, committed BCD digits and status out.
interface rgb_value_sampler_if;
    logic [9:0]  HCnt;
    logic [9:0]  VCnt;
    logic [15:0] frame_pixel;
    logic        freeze;
    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_unit;
    logic [3:0]  g_hund;
    logic [3:0]  g_tens;
    logic [3:0]  g_unit;
    logic [3:0]  b_hund;
    logic [3:0]  b_tens;
    logic [3:0]  b_unit;
    logic [23:0] rgb888;
    logic        update;
    logic        busy;

    modport master (
        output HCnt, VCnt, frame_pixel, freeze,
        input  r_hund, r_tens, r_unit, g_hund, g_tens, g_unit,
        input  b_hund, b_tens, b_unit, rgb888, update, busy
    );

    modport slave (
        input  HCnt, VCnt, frame_pixel, freeze,
        output r_hund, r_tens, r_unit, g_hund, g_tens, g_unit,
        output b_hund, b_tens, b_unit, rgb888, update, busy
    );
endinterface

// File: rtl/rgb_value_sampler.sv
// Samples one RGB565 pixel per frame, expands to RGB888 and converts each channel to
// BCD with a shared double-dabble; commits in vblank. Optional SAMPLE_AVG_EN averages 4 pixels.
module rgb_value_sampler #(
    parameter logic [9:0] SAMPLE_H     = 10'd320,
    parameter logic [9:0] SAMPLE_V     = 10'd240,
    parameter logic [9:0] PIX_LAT      = 10'd1,
    parameter logic [9:0] VBLANK_START = 10'd480
) (
    input  logic                clk25,
    input  logic                rst_n,
    rgb_value_sampler_if.slave  bus
);
    localparam logic [9:0] TRIG_H = SAMPLE_H + PIX_LAT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        PEND = 2'd2,
        CAPT = 2'd3
    } state_t;

    function automatic logic [23:0] expand565(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] dd_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic        trig_s;
    logic        load_s;
    logic        step_s;
    logic        commit_s;
    logic [15:0] word_s;
    logic [15:0] pix_r;
    logic [23:0] pix_exp_s;
    logic [1:0]  ch_r;
    logic [2:0]  bit_r;
    logic [11:0] bcd_r;
    logic [7:0]  bin_r;
    logic [19:0] shifted_s;
    logic [7:0]  next_bin_s;
    logic [35:0] pend_r;
    logic [35:0] dig_r;
    logic [23:0] rgb_r;
    logic        update_r;
    logic        busy_r;

`ifdef SAMPLE_AVG_EN
    logic        cap_s;
    logic [1:0]  cap_cnt_r;
    logic [6:0]  sum_r_r;
    logic [7:0]  sum_g_r;
    logic [6:0]  sum_b_r;
    logic [6:0]  sr_full_s;
    logic [7:0]  sg_full_s;
    logic [6:0]  sb_full_s;

    assign sr_full_s = sum_r_r + {2'b00, bus.frame_pixel[15:11]};
    assign sg_full_s = sum_g_r + {2'b00, bus.frame_pixel[10:5]};
    assign sb_full_s = sum_b_r + {2'b00, bus.frame_pixel[4:0]};
    assign word_s    = {sr_full_s[6:2], sg_full_s[7:2], sb_full_s[6:2]};
`else
    assign word_s    = bus.frame_pixel;
`endif

    assign trig_s     = (bus.HCnt == TRIG_H) && (bus.VCnt == SAMPLE_V) && !bus.freeze;
    assign pix_exp_s  = expand565(pix_r);
    assign shifted_s  = {dd_adjust(bcd_r), bin_r} << 1;
    assign next_bin_s = (ch_r == 2'd0) ? pix_exp_s[15:8] :
                        (ch_r == 2'd1) ? pix_exp_s[7:0]  : 8'd0;

    // State register.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        commit_s   = 1'b0;
`ifdef SAMPLE_AVG_EN
        cap_s      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (trig_s) begin
`ifdef SAMPLE_AVG_EN
                    cap_s      = 1'b1;
                    state_nx_s = CAPT;
`else
                    load_s     = 1'b1;
                    state_nx_s = CONV;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CAPT: begin
`ifdef SAMPLE_AVG_EN
                if (bus.freeze) begin
                    state_nx_s = IDLE;
                end else if (cap_cnt_r == 2'd3) begin
                    cap_s      = 1'b1;
                    load_s     = 1'b1;
                    state_nx_s = CONV;
                end else begin
                    cap_s      = 1'b1;
                    state_nx_s = CAPT;
                end
`else
                state_nx_s = IDLE;
`endif
            end
            CONV: begin
                step_s = 1'b1;
                if ((bit_r == 3'd7) && (ch_r == 2'd2)) begin
                    state_nx_s = PEND;
                end else begin
                    state_nx_s = CONV;
                end
            end
            PEND: begin
                if (bus.VCnt >= VBLANK_START) begin
                    commit_s   = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = PEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

`ifdef SAMPLE_AVG_EN
    // Per-channel running sums; cleared whenever no capture is in progress.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            cap_cnt_r <= 2'd0;
            sum_r_r   <= 7'd0;
            sum_g_r   <= 8'd0;
            sum_b_r   <= 7'd0;
        end else if (cap_s && !load_s) begin
            cap_cnt_r <= cap_cnt_r + 2'd1;
            sum_r_r   <= sr_full_s;
            sum_g_r   <= sg_full_s;
            sum_b_r   <= sb_full_s;
        end else begin
            cap_cnt_r <= 2'd0;
            sum_r_r   <= 7'd0;
            sum_g_r   <= 8'd0;
            sum_b_r   <= 7'd0;
        end
    end
`endif

    // Shared double-dabble: one step per cycle, channels R, G, B in turn.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            pix_r  <= 16'd0;
            ch_r   <= 2'd0;
            bit_r  <= 3'd0;
            bcd_r  <= 12'd0;
            bin_r  <= 8'd0;
            pend_r <= 36'd0;
        end else if (load_s) begin
            pix_r  <= word_s;
            ch_r   <= 2'd0;
            bit_r  <= 3'd0;
            bcd_r  <= 12'd0;
            bin_r  <= {word_s[15:11], word_s[15:13]};
        end else if (step_s) begin
            if (bit_r == 3'd7) begin
                case (ch_r)
                    2'd0:    pend_r[35:24] <= shifted_s[19:8];
                    2'd1:    pend_r[23:12] <= shifted_s[19:8];
                    2'd2:    pend_r[11:0]  <= shifted_s[19:8];
                    default: pend_r        <= pend_r;
                endcase
                ch_r  <= ch_r + 2'd1;
                bit_r <= 3'd0;
                bcd_r <= 12'd0;
                bin_r <= next_bin_s;
            end else begin
                bit_r <= bit_r + 3'd1;
                bcd_r <= shifted_s[19:8];
                bin_r <= shifted_s[7:0];
            end
        end else begin
            pix_r <= pix_r;
        end
    end

    // Output registers: all digits and rgb888 change together on the commit cycle.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            dig_r    <= 36'd0;
            rgb_r    <= 24'd0;
            update_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            update_r <= commit_s;
            busy_r   <= (state_nx_s == CONV) || (state_nx_s == PEND);
            if (commit_s) begin
                dig_r <= pend_r;
                rgb_r <= pix_exp_s;
            end else begin
                dig_r <= dig_r;
            end
        end
    end

    assign bus.r_hund = dig_r[35:32];
    assign bus.r_tens = dig_r[31:28];
    assign bus.r_unit = dig_r[27:24];
    assign bus.g_hund = dig_r[23:20];
    assign bus.g_tens = dig_r[19:16];
    assign bus.g_unit = dig_r[15:12];
    assign bus.b_hund = dig_r[11:8];
    assign bus.b_tens = dig_r[7:4];
    assign bus.b_unit = dig_r[3:0];
    assign bus.rgb888 = rgb_r;
    assign bus.update = update_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_rgb_value_sampler.sv
// Directed bench for rgb_value_sampler: drives scan counters directly (jumping lines)
// and checks committed BCD digits, rgb888, update timing and busy.
module tb_rgb_value_sampler;
    logic clk25 = 1'b0;
    logic rst_n;
    always #20 clk25 = ~clk25;

    rgb_value_sampler_if bus();

    rgb_value_sampler dut (
        .clk25 (clk25),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;
    int pulse_v     = 0;
    int glitches    = 0;
    logic [59:0] prev_out = 60'd0;

    function automatic logic [35:0] digits();
        return {bus.r_hund, bus.r_tens, bus.r_unit,
                bus.g_hund, bus.g_tens, bus.g_unit,
                bus.b_hund, bus.b_tens, bus.b_unit};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [59:0] cur;
        @(posedge clk25);
        #1;
        cur = {digits(), bus.rgb888};
        if (bus.update === 1'b1) begin
            pulses++;
            pulse_v = int'(bus.VCnt);
        end else if (cur !== prev_out) begin
            glitches++;
        end else begin
            glitches = glitches;
        end
        prev_out = cur;
    endtask

    task automatic head(input logic [15:0] p0, input logic [15:0] p1,
                        input logic [15:0] p2, input logic [15:0] p3, input logic frz);
        bus.VCnt   = 10'd240;
        bus.freeze = frz;
        for (int h = 318; h <= 330; h++) begin
            bus.HCnt = 10'(h);
            case (h)
                322:     bus.frame_pixel = p1;
                323:     bus.frame_pixel = p2;
                324:     bus.frame_pixel = p3;
                default: bus.frame_pixel = p0;
            endcase
            tick();
        end
    endtask

    task automatic tail();
        bus.HCnt = 10'd0;
        bus.VCnt = 10'd300; repeat (30) tick();
        bus.VCnt = 10'd479; repeat (3) tick();
        bus.VCnt = 10'd480; repeat (3) tick();
        bus.VCnt = 10'd500; repeat (3) tick();
    endtask

    task automatic frame(input logic [15:0] p, input logic frz);
        pulses   = 0;
        glitches = 0;
        head(p, p, p, p, frz);
        tail();
    endtask

    task automatic check_frame(input string tag, input int exp_pulses,
                               input logic [35:0] exp_dig, input logic [23:0] exp_rgb);
        chk({tag, "_pulses"}, 40'(pulses), 40'(exp_pulses));
        if (exp_pulses == 1) begin
            chk({tag, "_pulse_line"}, 40'(pulse_v), 40'd480);
        end else begin
            chk({tag, "_no_pulse"}, 40'(pulses), 40'd0);
        end
        chk({tag, "_stable"}, 40'(glitches), 40'd0);
        chk({tag, "_digits"}, {4'd0, digits()}, {4'd0, exp_dig});
        chk({tag, "_rgb888"}, {16'd0, bus.rgb888}, {16'd0, exp_rgb});
        chk({tag, "_busy"}, {39'd0, bus.busy}, 40'd0);
    endtask

    initial begin
        bus.HCnt        = 10'd0;
        bus.VCnt        = 10'd0;
        bus.frame_pixel = 16'd0;
        bus.freeze      = 1'b0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk25);
        #1;
        chk("rst_digits", {4'd0, digits()}, 40'd0);
        chk("rst_rgb888", {16'd0, bus.rgb888}, 40'd0);
        chk("rst_update", {39'd0, bus.update}, 40'd0);
        chk("rst_busy", {39'd0, bus.busy}, 40'd0);
        rst_n = 1'b1;
        tick();

        frame(16'hF800, 1'b0);
        check_frame("red", 1, 36'h255_000_000, 24'hFF0000);
        frame(16'h8410, 1'b0);
        check_frame("mid", 1, 36'h132_130_132, 24'h848284);
        frame(16'hFFFF, 1'b0);
        check_frame("white", 1, 36'h255_255_255, 24'hFFFFFF);
        frame(16'h0000, 1'b0);
        check_frame("black", 1, 36'h000_000_000, 24'h000000);
        frame(16'h8410, 1'b0);
        check_frame("mid2", 1, 36'h132_130_132, 24'h848284);

        frame(16'hFFFF, 1'b1);
        check_frame("frz1", 0, 36'h132_130_132, 24'h848284);
        frame(16'hF800, 1'b1);
        check_frame("frz2", 0, 36'h132_130_132, 24'h848284);
        frame(16'h001F, 1'b0);
        check_frame("blue", 1, 36'h000_000_255, 24'h0000FF);

        // Reset ten cycles into the conversion.
        pulses          = 0;
        bus.VCnt        = 10'd240;
        bus.freeze      = 1'b0;
        bus.frame_pixel = 16'hFFFF;
        bus.HCnt        = 10'd321;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.HCnt = 10'd322 + 10'(i);
            tick();
        end
        chk("conv_busy", {39'd0, bus.busy}, 40'd1);
        rst_n = 1'b0;
        #2;
        chk("midrst_digits", {4'd0, digits()}, 40'd0);
        chk("midrst_rgb888", {16'd0, bus.rgb888}, 40'd0);
        chk("midrst_busy", {39'd0, bus.busy}, 40'd0);
        chk("midrst_update", {39'd0, bus.update}, 40'd0);
        tick();
        tick();
        rst_n    = 1'b1;
        prev_out = {digits(), bus.rgb888};
        tail();
        chk("midrst_no_pulse", 40'(pulses), 40'd0);
        chk("midrst_held_zero", {4'd0, digits()}, 40'd0);
        frame(16'h8410, 1'b0);
        check_frame("after_rst", 1, 36'h132_130_132, 24'h848284);

`ifdef SAMPLE_AVG_EN
        pulses   = 0;
        glitches = 0;
        head(16'hF800, 16'hF800, 16'h0000, 16'h0000, 1'b0);
        tail();
        check_frame("avg", 1, 36'h123_000_000, 24'h7B0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
